// File: rtl/config_arbiter.sv
// config_arbiter: round-robin front end for the shared ConfigurationUnit.
// Picks one of two requesters, checks the requester's key against the master
// key, then drives the unit's request/confirm/key/data handshake. Repeated key
// failures put the block into a timed lockout. Every output is registered.
module config_arbiter #(
    parameter logic [7:0] KEY         = 8'hA5,
    parameter int         MAX_FAIL    = 3,
    parameter int         HOLD_CYCLES = 2,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [1:0] req,
    input  logic [7:0] key0,
    input  logic [7:0] key1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [1:0] denied,
    output logic       locked,
    output logic [1:0] failCount,
    output logic       cfgRequest,
    output logic       cfgConfirm,
    output logic [7:0] cfgKey,
    output logic [7:0] cfgData
);

    // One counter serves both the REQ hold time and the lockout time.
    localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        REQ     = 3'd2,
        CONFIRM = 3'd3,
        DONE    = 3'd4,
        DENY    = 3'd5,
        LOCKED  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fail_q, fail_d;
    logic [1:0]       fail_inc;
    logic             ptr_q, ptr_d;
    logic             winner_q, winner_d;
    logic [7:0]       key_q, key_d;
    logic [7:0]       data_q, data_d;

    // Registered outputs and their next values.
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q, done_d;
    logic [1:0] denied_q, denied_d;
    logic       locked_q, locked_d;
    logic       cfg_req_q, cfg_req_d;
    logic       cfg_conf_q, cfg_conf_d;
    logic [7:0] cfg_key_q, cfg_key_d;
    logic [7:0] cfg_data_q, cfg_data_d;

    // Per-requester views: key/data arrays and one-hot decodes of the
    // candidate winner (this cycle) and of the latched winner.
    logic [7:0] key_arr  [2];
    logic [7:0] data_arr [2];
    logic [1:0] cand_oh;
    logic [1:0] win_oh;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign key_arr[gi]  = (gi == 0) ? key0  : key1;
            assign data_arr[gi] = (gi == 0) ? data0 : data1;
            assign cand_oh[gi]  = (winner_d == 1'(gi));
            assign win_oh[gi]   = (winner_q == 1'(gi));
        end
    endgenerate

    assign fail_inc = fail_q + 2'd1;

    // State register plus the datapath latches that move with it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fail_q   <= 2'd0;
            ptr_q    <= 1'b0;
            winner_q <= 1'b0;
            key_q    <= 8'd0;
            data_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            key_q    <= key_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic: arbitration, key check, hold and lockout timing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        key_d    = key_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // A lone request wins outright; a tie goes to the pointer.
                    if (req == 2'b01)      winner_d = 1'b0;
                    else if (req == 2'b10) winner_d = 1'b1;
                    else                   winner_d = ptr_q;
                    key_d   = key_arr[winner_d];
                    data_d  = data_arr[winner_d];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (key_q == KEY) begin
                    fail_d  = 2'd0;
                    state_d = REQ;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == 2'(MAX_FAIL)) ? LOCKED : DENY;
                end
            end
            REQ: begin
                // Requester withdrawing mid-hold abandons the transaction quietly.
                if (!req[winner_q])                           state_d = IDLE;
                else if (cnt_q == CNT_W'(HOLD_CYCLES - 1))    state_d = CONFIRM;
                else                                          cnt_d   = cnt_q + 1'b1;
            end
            CONFIRM: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                ptr_d   = ~winner_q;
            end
            DENY: begin
                state_d = IDLE;
                ptr_d   = ~winner_q;
            end
            LOCKED: begin
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                    fail_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: derive every registered output from the upcoming state.
    always_comb begin
        grant_d = grant_q;
        if (state_q == IDLE && state_d == CHECK)     grant_d = cand_oh;
        else if (state_d == IDLE || state_d == LOCKED) grant_d = 2'b00;

        done_d   = (state_d == DONE) ? win_oh : 2'b00;
        denied_d = (state_d == DENY || (state_q == CHECK && state_d == LOCKED))
                   ? win_oh : 2'b00;
        locked_d = (state_d == LOCKED);

        cfg_req_d  = (state_d == REQ) || (state_d == CONFIRM);
        cfg_conf_d = (state_d == CONFIRM);
        cfg_key_d  = cfg_req_d ? key_q  : 8'd0;
        cfg_data_d = cfg_req_d ? data_q : 8'd0;
    end

    // Output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            denied_q   <= 2'b00;
            locked_q   <= 1'b0;
            cfg_req_q  <= 1'b0;
            cfg_conf_q <= 1'b0;
            cfg_key_q  <= 8'd0;
            cfg_data_q <= 8'd0;
        end else begin
            grant_q    <= grant_d;
            done_q     <= done_d;
            denied_q   <= denied_d;
            locked_q   <= locked_d;
            cfg_req_q  <= cfg_req_d;
            cfg_conf_q <= cfg_conf_d;
            cfg_key_q  <= cfg_key_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign denied     = denied_q;
    assign locked     = locked_q;
    assign failCount  = fail_q;
    assign cfgRequest = cfg_req_q;
    assign cfgConfirm = cfg_conf_q;
    assign cfgKey     = cfg_key_q;
    assign cfgData    = cfg_data_q;

endmodule

// File: tb/tb_config_arbiter.sv
// Testbench for config_arbiter: directed scenarios plus a randomized run,
// all checked cycle by cycle against a transaction-level timeline model.
module tb_config_arbiter;

    localparam logic [7:0] KEY  = 8'hA5;
    localparam int         MAXF = 3;
    localparam int         HOLD = 2;
    localparam int         LOCK = 16;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] key0 = 8'd0, key1 = 8'd0, data0 = 8'd0, data1 = 8'd0;
    logic [1:0] grant, done, denied, failCount;
    logic       locked, cfgRequest, cfgConfirm;
    logic [7:0] cfgKey, cfgData;

    config_arbiter #(.KEY(KEY), .MAX_FAIL(MAXF), .HOLD_CYCLES(HOLD), .LOCK_CYCLES(LOCK)) dut (
        .clock(clock), .resetN(resetN), .req(req),
        .key0(key0), .key1(key1), .data0(data0), .data1(data1),
        .grant(grant), .done(done), .denied(denied), .locked(locked),
        .failCount(failCount), .cfgRequest(cfgRequest), .cfgConfirm(cfgConfirm),
        .cfgKey(cfgKey), .cfgData(cfgData)
    );

    always #5 clock = ~clock;

    // Output snapshot: grant,done,denied,locked,failCount,cfgRequest,cfgConfirm,cfgKey,cfgData
    logic [26:0] obs_now;
    assign obs_now = {grant, done, denied, locked, failCount, cfgRequest, cfgConfirm, cfgKey, cfgData};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: consecutive failures and round-robin preference.
    int m_fail = 0;
    int m_ptr  = 0;

    logic [26:0] obs_q[$];
    logic [26:0] exp_q[$];

    task automatic apply_reset();
        resetN = 1'b0;
        req    = 2'b00;
        @(negedge clock);
        resetN = 1'b1;
        m_fail = 0;
        m_ptr  = 0;
    endtask

    // Drives one transaction starting at the current negedge (next posedge is
    // edge 0) and records observed/expected snapshots after each edge.
    task automatic run_txn(input logic [1:0] rq, input logic [7:0] k0, input logic [7:0] k1,
                           input logic [7:0] d0, input logic [7:0] d1, input int drop_at,
                           input logic keep_loser, input logic [1:0] extra_req, input int rst_at);
        int w, newfail, last;
        logic good, lock;
        logic [1:0] oh, g, dn, dd, fc;
        logic lk, cr, cc;
        logic [7:0] kw, dw, ck, cd;
        w       = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : m_ptr;
        oh      = (w == 0) ? 2'b01 : 2'b10;
        kw      = (w == 0) ? k0 : k1;
        dw      = (w == 0) ? d0 : d1;
        good    = (kw == KEY);
        newfail = good ? 0 : m_fail + 1;
        lock    = !good && (newfail == MAXF);
        if (good && drop_at > 0) last = drop_at + 1;
        else if (good)           last = HOLD + 3;
        else if (lock)           last = LOCK + 1;
        else                     last = 2;
        req = rq; key0 = k0; key1 = k1; data0 = d0; data1 = d1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            if (k == 0) begin
                // Latched values must be used from here on.
                key0 = 8'($urandom); key1 = 8'($urandom);
                data0 = 8'($urandom); data1 = 8'($urandom);
            end
            g = 2'b00; dn = 2'b00; dd = 2'b00; lk = 1'b0; cr = 1'b0; cc = 1'b0;
            ck = 8'd0; cd = 8'd0;
            fc = (k == 0) ? 2'(m_fail) : 2'(newfail);
            if (k == 0) begin
                g = oh;
            end else if (good) begin
                if ((drop_at > 0) ? (k <= drop_at) : (k <= HOLD + 1)) begin
                    g = oh; cr = 1'b1; ck = kw; cd = dw;
                    cc = (drop_at == 0) && (k == HOLD + 1);
                end else if (drop_at == 0 && k == HOLD + 2) begin
                    g = oh; dn = oh;
                end
            end else if (lock) begin
                lk = (k <= LOCK);
                dd = (k == 1) ? oh : 2'b00;
                fc = (k <= LOCK) ? 2'(MAXF) : 2'd0;
            end else if (k == 1) begin
                g = oh; dd = oh;
            end
            exp_q.push_back({g, dn, dd, lk, fc, cr, cc, ck, cd});
            obs_q.push_back(obs_now);
            if (k == rst_at) begin
                resetN = 1'b0;
                #1;
                exp_q.push_back(27'd0);
                obs_q.push_back(obs_now);
                @(negedge clock);
                req    = 2'b00;
                resetN = 1'b1;
                m_fail = 0;
                m_ptr  = 0;
                return;
            end
            if (good && drop_at > 0 && k == drop_at)         req = 2'b00;
            if (good && drop_at == 0 && k == HOLD + 2)       req = keep_loser ? (rq & ~oh) : 2'b00;
            if (!good && k == 1)                             req = (keep_loser ? (rq & ~oh) : 2'b00) | (lock ? extra_req : 2'b00);
        end
        if (good) begin
            m_fail = 0;
            if (drop_at == 0) m_ptr = 1 - w;
        end else if (lock) begin
            m_fail = 0;
        end else begin
            m_fail = newfail;
            m_ptr  = 1 - w;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #3;
        n_cmp++;
        if (obs_now !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", obs_now, 27'd0);
        end
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        m_fail = 0;
        m_ptr  = 0;
        $display("test_reset: outputs after reset %h", obs_now);
    endtask

    task automatic test_single();
        logic [26:0] o, e;
        run_txn(2'b01, KEY, 8'h00, 8'h3C, 8'h00, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL single cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_single: req=01 key=A5 data=3C done");
    endtask

    task automatic test_back_to_back();
        logic [26:0] o, e;
        apply_reset();
        run_txn(2'b11, KEY, KEY, 8'h11, 8'h22, 0, 1'b1, 2'b00, -1);
        run_txn(2'b10, KEY, KEY, 8'h33, 8'h22, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL back_to_back cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_back_to_back: req=11 served 0 then 1");
    endtask

    task automatic test_bad_key();
        logic [26:0] o, e;
        run_txn(2'b01, 8'h00, KEY, 8'h55, 8'h00, 0, 1'b0, 2'b00, -1);
        run_txn(2'b01, 8'h00, KEY, 8'h66, 8'h00, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL bad_key cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_bad_key: two denials, model failCount=%0d", m_fail);
    endtask

    task automatic test_lockout();
        logic [26:0] o, e;
        run_txn(2'b01, 8'h00, KEY, 8'h77, 8'h88, 0, 1'b0, 2'b10, -1);
        run_txn(2'b10, 8'h00, KEY, 8'h00, 8'h99, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL lockout cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_lockout: lockout then requester 1 served");
    endtask

    task automatic test_abort();
        logic [26:0] o, e;
        run_txn(2'b01, KEY, 8'h00, 8'h12, 8'h00, 1, 1'b0, 2'b00, -1);
        run_txn(2'b01, KEY, 8'h00, 8'h34, 8'h00, HOLD, 1'b0, 2'b00, -1);
        run_txn(2'b01, KEY, 8'h00, 8'h56, 8'h00, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL abort cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_abort: two aborts then normal service");
    endtask

    task automatic test_reset_mid();
        logic [26:0] o, e;
        run_txn(2'b01, KEY, 8'h00, 8'hAB, 8'h00, 0, 1'b0, 2'b00, HOLD + 1);
        run_txn(2'b01, KEY, 8'h00, 8'hCD, 8'h00, 0, 1'b0, 2'b00, -1);
        run_txn(2'b10, 8'h00, 8'h01, 8'h00, 8'h01, 0, 1'b0, 2'b00, -1);
        run_txn(2'b10, 8'h00, 8'h02, 8'h00, 8'h02, 0, 1'b0, 2'b00, -1);
        run_txn(2'b01, 8'h03, 8'h00, 8'h03, 8'h00, 0, 1'b0, 2'b00, 5);
        run_txn(2'b01, KEY, 8'h00, 8'hEF, 8'h00, 0, 1'b0, 2'b00, -1);
        for (int i = 0; obs_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL reset_mid cyc%0d: got %h expected %h", i, o, e); end
        end
        $display("test_reset_mid: reset in CONFIRM and in LOCKED");
    endtask

    task automatic test_random();
        logic [26:0] o, e;
        logic [1:0] rq;
        logic [7:0] k0, k1;
        int drop;
        for (int t = 0; t < 40; t++) begin
            rq   = 2'($urandom_range(1, 3));
            k0   = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
            k1   = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HOLD)) : 0;
            run_txn(rq, k0, k1, 8'($urandom), 8'($urandom), drop, 1'b0, 2'b00, -1);
            for (int i = 0; obs_q.size() > 0; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL random t%0d cyc%0d: got %h expected %h", t, i, o, e); end
            end
            $display("test_random: txn %0d req=%b k0=%h k1=%h drop=%0d", t, rq, k0, k1, drop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_key();
        test_lockout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
